// File: rtl/keypad_scan_fifo.sv
// Column-scanned matrix keypad with debounce, optional auto-repeat and an event FIFO.
// Key index = row*COLS + col; ColOut and RowIn are active-low.
module keypad_scan_fifo #(
   parameter int unsigned ROWS          = 4,
   parameter int unsigned COLS          = 4,
   parameter int unsigned SCAN_DIV      = 4,
   parameter int unsigned DEBOUNCE      = 2,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned REPEAT_FRAMES = 0,
   localparam int unsigned KW           = $clog2(ROWS*COLS),
   localparam int unsigned CW           = $clog2(DEPTH+1)
) (
   input  logic            clk,
   input  logic            nRST,
   output logic [COLS-1:0] ColOut,
   input  logic [ROWS-1:0] RowIn,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   input  logic            key_read,
   output logic [CW-1:0]   fifo_count,
   output logic            overflow,
   input  logic            ovf_clr
);

   localparam int unsigned DIVW = $clog2(SCAN_DIV);
   localparam int unsigned CLW  = $clog2(COLS);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned DW   = $clog2(DEBOUNCE+1);
   localparam int unsigned RW   = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES+1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;

   logic [DIVW-1:0]            div;
   logic [CLW-1:0]             col;
   logic [ROWS-1:0]            row_meta, row_sync;
   logic [COLS-2:0][ROWS-1:0]  frame_q;
   logic [COLS-1:0][ROWS-1:0]  frame_full;
   logic                       sample, frame_done;

   assign sample     = (div == DIVW'(SCAN_DIV-1));
   assign frame_done = sample && (col == CLW'(COLS-1));
   // The last column is taken straight from the synchroniser so the frame can be judged on its final sample.
   assign frame_full = {row_sync, frame_q};

   // Column scanner, row synchroniser and frame capture
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         div      <= '0;
         col      <= '0;
         ColOut   <= ~COLS'(1);
         row_meta <= '1;
         row_sync <= '1;
         frame_q  <= '1;
      end else begin
         row_meta <= RowIn;
         row_sync <= row_meta;
         if (sample) begin
            div <= '0;
            if (frame_done) begin
               col    <= '0;
               ColOut <= ~COLS'(1);
            end else begin
               frame_q[col] <= row_sync;
               col          <= col + CLW'(1);
               ColOut       <= ~(COLS'(1) << (col + CLW'(1)));
            end
         end else begin
            div <= div + DIVW'(1);
         end
      end
   end

   // Classify the completed frame: nkeys saturates at 2 (meaning "multiple")
   logic [1:0]    nkeys;
   logic [KW-1:0] kidx;

   always_comb begin
      nkeys = 2'd0;
      kidx  = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
         for (int c = 0; c < int'(COLS); c++) begin
            if (!frame_full[c][r]) begin
               if (nkeys != 2'd2) nkeys = nkeys + 2'd1;
               kidx = KW'(r*COLS + c);
            end
         end
      end
   end

   state_t        state, state_n;
   logic [KW-1:0] cand, cand_n;
   logic [DW-1:0] cnt, cnt_n;
   logic [RW-1:0] rep, rep_n;
   logic          push_q, push_n;
   logic [KW-1:0] push_code;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state     <= S_IDLE;
         cand      <= '0;
         cnt       <= '0;
         rep       <= '0;
         push_q    <= 1'b0;
         push_code <= '0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         rep       <= rep_n;
         push_q    <= push_n;
         push_code <= cand_n;
      end
   end

   // cnt counts press frames in DEBOUNCE and release frames in HELD
   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      rep_n   = rep;
      push_n  = 1'b0;
      if (frame_done) begin
         case (state)
            S_IDLE: begin
               if (nkeys == 2'd1) begin
                  cand_n = kidx;
                  if (DEBOUNCE == 1) begin
                     push_n  = 1'b1;
                     state_n = S_HELD;
                     cnt_n   = '0;
                     rep_n   = '0;
                  end else begin
                     cnt_n   = DW'(1);
                     state_n = S_DEBOUNCE;
                  end
               end
            end
            S_DEBOUNCE: begin
               if (nkeys == 2'd1 && kidx == cand) begin
                  if (cnt + DW'(1) == DW'(DEBOUNCE)) begin
                     push_n  = 1'b1;
                     state_n = S_HELD;
                     cnt_n   = '0;
                     rep_n   = '0;
                  end else begin
                     cnt_n = cnt + DW'(1);
                  end
               end else begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end
            end
            S_HELD: begin
               if (nkeys == 2'd0) begin
                  if (cnt + DW'(1) == DW'(DEBOUNCE)) begin
                     state_n = S_IDLE;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + DW'(1);
                  end
               end else begin
                  cnt_n = '0;
               end
               if (REPEAT_FRAMES > 0) begin
                  if (nkeys == 2'd1 && kidx == cand) begin
                     if (rep + RW'(1) == RW'(REPEAT_FRAMES)) begin
                        push_n = 1'b1;
                        rep_n  = '0;
                     end else begin
                        rep_n = rep + RW'(1);
                     end
                  end else begin
                     rep_n = '0;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Event FIFO; key_code/key_valid are registered views of the next head
   logic [KW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [CW-1:0] count_next;
   logic [KW-1:0] head_next;
   logic          full, pop, push_ok;

   assign full       = (fifo_count == CW'(DEPTH));
   assign pop        = key_read && key_valid;
   assign push_ok    = push_q && (!full || pop);
   assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
   assign count_next = fifo_count + CW'(push_ok) - CW'(pop);
   assign head_next  = (push_ok && rd_next == wr_ptr) ? push_code : mem[rd_next];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_code;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         key_valid  <= 1'b0;
         key_code   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr     <= rd_next;
         fifo_count <= count_next;
         key_valid  <= (count_next != '0);
         key_code   <= (count_next != '0) ? head_next : '0;
         if (push_q && full && !pop) overflow <= 1'b1;
         else if (ovf_clr)           overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench for keypad_scan_fifo: a keypad model drives RowIn from the pressed-key set,
// monitors pop and compare events against queues filled by the directed stimulus.
module tb_keypad_scan_fifo;

   logic        clk = 1'b0;
   logic        nRST;
   logic [15:0] keys, keys2;
   logic [3:0]  col_out, row_in, col_out2, row_in2;
   logic [3:0]  key_code, key_code2;
   logic        key_valid, key_valid2;
   logic        key_read, key_read2;
   logic [2:0]  fifo_count, fifo_count2;
   logic        overflow, overflow2;
   logic        ovf_clr;
   bit          reads_en;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0_2     = 0;
   int exp_q[$];
   int exp2_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [3:0] co);
      logic [3:0] rv = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (k[r*4+c] && !co[c]) rv[r] = 1'b0;
      return rv;
   endfunction

   assign row_in  = rows_of(keys,  col_out);
   assign row_in2 = rows_of(keys2, col_out2);

   keypad_scan_fifo dut (
      .clk(clk), .nRST(nRST), .ColOut(col_out), .RowIn(row_in),
      .key_code(key_code), .key_valid(key_valid), .key_read(key_read),
      .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr));

   keypad_scan_fifo #(.REPEAT_FRAMES(3)) dut_rep (
      .clk(clk), .nRST(nRST), .ColOut(col_out2), .RowIn(row_in2),
      .key_code(key_code2), .key_valid(key_valid2), .key_read(key_read2),
      .fifo_count(fifo_count2), .overflow(overflow2), .ovf_clr(1'b0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic flag_unexpected(input string name, input int code);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event code %0d, expected no event", name, code);
   endtask

   // Monitor for the default instance: pop whatever it presents and check against the queue
   always @(negedge clk) begin
      key_read = 1'b0;
      if (reads_en && nRST && key_valid) begin
         if (exp_q.size() == 0) flag_unexpected("unexpected_event", int'(key_code));
         else chk("event_code", 32'(key_code), exp_q.pop_front());
         key_read = 1'b1;
      end
   end

   // Monitor for the auto-repeat instance: checks the code and the frame the event was accepted in
   always @(negedge clk) begin
      int f;
      key_read2 = 1'b0;
      if (nRST && key_valid2) begin
         if (exp2_q.size() == 0) flag_unexpected("unexpected_rep_event", int'(key_code2));
         else begin
            f = exp2_q.pop_front();
            chk("rep_code", 32'(key_code2), 32'd9);
            chk("rep_frame", (cyc - t0_2 - 1) / 16, f);
         end
         key_read2 = 1'b1;
      end
   end

   // Align to the first cycle of a column-0 slot (bounded)
   task automatic sync_frame();
      logic [3:0] prev;
      bit ok = 1'b0;
      prev = col_out;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (col_out == 4'b1110 && prev == 4'b0111) begin
            ok = 1'b1;
            break;
         end
         prev = col_out;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL sync_frame: got ColOut %b, expected a 0111->1110 transition", col_out);
      end
   endtask

   task automatic frames(input int n);
      repeat (16*n) @(negedge clk);
   endtask

   task automatic press(input int k, input int n_hold, input int n_rel);
      keys = 16'(1) << k;
      frames(n_hold);
      keys = '0;
      frames(n_rel);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e;
      nRST = 1'b0; keys = '0; keys2 = '0; ovf_clr = 1'b0; reads_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_colout",  32'(col_out),    32'hE);
      chk("rst_valid",   32'(key_valid),  0);
      chk("rst_count",   32'(fifo_count), 0);
      chk("rst_ovf",     32'(overflow),   0);
      chk("rst_code",    32'(key_code),   0);

      // Column sequence after reset release, 4 cycles per column
      nRST = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         e = ~(4'b0001 << (i/4));
         chk("col_seq", 32'(col_out), 32'(e));
      end

      // Single key 6 held 4 frames then released: one event
      reads_en = 1'b1;
      sync_frame();
      exp_q.push_back(6);
      press(6, 4, 3);
      chk("k6_valid_after_read", 32'(key_valid),  0);
      chk("k6_count_after_read", 32'(fifo_count), 0);
      chk("k6_drained",          exp_q.size(),    0);

      // One-frame glitch and two-key chord: no events
      press(6, 1, 3);
      keys = (16'(1) << 0) | (16'(1) << 5);
      frames(4);
      keys = '0;
      frames(3);
      chk("noevt_count", 32'(fifo_count), 0);
      chk("noevt_valid", 32'(key_valid),  0);

      // Five presses without reads: fifth is dropped and overflow sticks
      reads_en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k < 5) exp_q.push_back(k);
         press(k, 3, 3);
      end
      chk("ovf_count", 32'(fifo_count), 4);
      chk("ovf_flag",  32'(overflow),   1);
      chk("ovf_valid", 32'(key_valid),  1);
      chk("ovf_head",  32'(key_code),   1);
      reads_en = 1'b1;
      repeat (8) @(negedge clk);
      chk("ovf_drained_count", 32'(fifo_count), 0);
      chk("ovf_sticky",        32'(overflow),   1);
      chk("ovf_drained",       exp_q.size(),    0);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 0);

      // Auto-repeat instance: key 9 held 10 frames -> events accepted at frames 2, 5, 8
      sync_frame();
      t0_2 = cyc;
      exp2_q.push_back(2);
      exp2_q.push_back(5);
      exp2_q.push_back(8);
      keys2 = 16'(1) << 9;
      frames(10);
      keys2 = '0;
      frames(3);
      chk("rep_drained", exp2_q.size(),      0);
      chk("rep_count",   32'(fifo_count2),   0);

      // Reset mid-debounce with two events queued
      reads_en = 1'b0;
      press(1, 3, 3);
      press(2, 3, 3);
      chk("pre_rst_count", 32'(fifo_count), 2);
      keys = 16'(1) << 6;
      frames(1);
      repeat (5) @(negedge clk);
      nRST = 1'b0;
      keys = '0;
      repeat (2) @(negedge clk);
      chk("midrst_count",  32'(fifo_count), 0);
      chk("midrst_valid",  32'(key_valid),  0);
      chk("midrst_colout", 32'(col_out),    32'hE);
      nRST = 1'b1;
      reads_en = 1'b1;
      sync_frame();
      frames(3);
      chk("postrst_count", 32'(fifo_count), 0);
      chk("postrst_valid", 32'(key_valid),  0);
      exp_q.push_back(6);
      press(6, 3, 3);
      chk("repress_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scan_fifo.md
KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 SHALL have parameter ROWS, 4, number of keypad rows (>=1).
REQ-002 SHALL have parameter COLS, 4, number of keypad columns (>=2).
REQ-003 SHALL have parameter SCAN_DIV, 4, clock cycles each column is driven (>=3).
REQ-004 SHALL have parameter DEBOUNCE, 2, consecutive identical frames needed to accept a press or a release (>=1).
REQ-005 SHALL have parameter DEPTH, 4, event FIFO depth (power of 2, >=2).
REQ-006 SHALL have parameter REPEAT_FRAMES, 0, auto-repeat interval in frames; 0 disables auto-repeat.
REQ-007 SHALL define KW = $clog2(ROWS*COLS) and CW = $clog2(DEPTH+1).
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 nRST  input  1  reset, asynchronous and active-low.
REQ-010 ColOut  output  COLS  column drive, active-low one-hot.
REQ-011 RowIn  input  ROWS  row sense, active-low, asynchronous to clk.
REQ-012 key_code  output  KW  key index at FIFO head; index = row*COLS + col.
REQ-013 key_valid  output  1  FIFO not empty.
REQ-014 key_read  input  1  single-cycle pop strobe, honoured only while key_valid=1.
REQ-015 fifo_count  output  CW  number of stored events.
REQ-016 overflow  output  1  sticky, set when an event is dropped.
REQ-017 ovf_clr  input  1  clears overflow.

Function
REQ-018 Scanner SHALL drive column c for SCAN_DIV cycles, ColOut = ~(1<<c), then advance c = 0..COLS-1, wrapping to 0.
REQ-019 RowIn SHALL pass through a 2-flop synchroniser; the synchronised value SHALL be sampled on the last cycle of each column slot into that column's frame bits.
REQ-020 A frame SHALL complete on the sample of column COLS-1; the FSM SHALL evaluate on that cycle: zero keys, exactly one key (index k), or multiple keys.
REQ-021 FSM states IDLE, DEBOUNCE, HELD.
REQ-022 IDLE: single key k -> latch cand=k, press count=1; push cand if DEBOUNCE==1 and go HELD, else go DEBOUNCE; zero or multiple keys -> stay IDLE.
REQ-023 DEBOUNCE: single key equal to cand -> increment count, push cand and go HELD when count reaches DEBOUNCE; any other frame -> IDLE, no push.
REQ-024 HELD: zero-key frame increments release count, and the FSM goes IDLE when it reaches DEBOUNCE; any non-zero frame clears release count.
REQ-025 HELD with REPEAT_FRAMES>0: repeat counter starts at 0 on entry, increments on each frame whose single key equals cand, pushes cand and clears itself at REPEAT_FRAMES; other frames clear it.
REQ-026 Push SHALL write at the tail one cycle after frame evaluation; key_valid/key_code SHALL reflect a push into an empty FIFO on the following cycle.
REQ-027 key_read while key_valid=1 SHALL pop the head; key_read while empty SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL both succeed at any fill level, including full, with fifo_count unchanged.
REQ-029 Push while full without a pop SHALL drop the new event, keep contents, and set overflow.
REQ-030 ovf_clr SHALL clear overflow; a simultaneous drop SHALL take priority and leave overflow set.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH.

Reset
REQ-032 nRST low SHALL immediately force: c=0, ColOut=~1, synchroniser and frame bits to released, FSM IDLE, all counters 0, FIFO empty, key_code=0, key_valid=0, fifo_count=0, overflow=0.
REQ-033 Reset mid-scan or mid-debounce SHALL discard partial frames and queued events; scanning SHALL restart at column 0 on the first edge after release.

Verification (defaults unless stated)
REQ-034 Reset -> ColOut=4'b1110, key_valid=0, fifo_count=0, overflow=0; column sequence 1110,1101,1011,0111 at 4 cycles each.
REQ-035 RowIn=4'b1101 while ColOut=4'b1011, held 4 frames, then released -> exactly one event, key_code=6; key_read -> key_valid=0.
REQ-036 Key 6 present for one frame only, or keys 0 and 5 pressed together for 4 frames -> no event.
REQ-037 Keys 1,2,3,4,5 pressed and released in order without reads -> fifo_count=4, overflow=1, pops give 1,2,3,4; ovf_clr -> overflow=0.
REQ-038 REPEAT_FRAMES=3, key 9 held 10 frames -> exactly 3 events of code 9, accepted at frames 2, 5, 8.
REQ-039 nRST pulsed while key 6 is mid-debounce with 2 events queued -> FIFO empty, no event from the interrupted press until released and pressed again.
